// File: rtl/seq_alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU.
// Imported by the top-level datapath and the bench.
package seq_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_REM = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle of the sequential ALU: valid/ready in, valid/ready out.
// master drives operations and accepts results; slave is the ALU itself.
interface seq_alu_if #(
  parameter int WIDTH = 8
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     num1;
  logic [WIDTH-1:0]     num2;
  logic [1:0]           sel;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 zero_flag;
  logic                 div_by_zero_flag;

  modport master (
    output in_valid, num1, num2, sel, out_ready,
    input  in_ready, out_valid, result, zero_flag, div_by_zero_flag
  );

  modport slave (
    input  in_valid, num1, num2, sel, out_ready,
    output in_ready, out_valid, result, zero_flag, div_by_zero_flag
  );

endinterface

// File: rtl/seq_alu_divstep.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor, restore on underflow.
// Purely combinational; the remainder stays below the divisor so WIDTH+1 bits never overflow.
module seq_alu_divstep #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic             o_q
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_diff;

  assign w_shift = {i_rem, i_bit};
  assign o_q     = (w_shift >= {2'b00, i_div});
  // When the subtract succeeds the true difference is below 2^(WIDTH+1), so modular math is exact.
  assign w_diff  = w_shift[WIDTH:0] - {1'b0, i_div};
  assign o_rem   = o_q ? w_diff : w_shift[WIDTH:0];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: ADD/SUB/REM-by-zero finish in 1 cycle, MUL/REM take WIDTH+1 cycles.
// One operation in flight; result is held in DONE until out_ready, input is refused until then.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  seq_alu_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH:0]       r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_opb;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_zero;
  logic                 r_dbz;

  logic [2*WIDTH-1:0]   w_res_nxt;
  logic                 w_zero_nxt;
  logic                 w_dbz_nxt;
  logic                 w_last;
  logic [WIDTH:0]       w_add;
  logic [WIDTH:0]       w_sub;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_rem_nxt;
  logic                 w_q;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_divres;

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_add    = {1'b0, bus.num1} + {1'b0, bus.num2};
  // Bit WIDTH of the extended difference is exactly the borrow.
  assign w_sub    = {1'b0, bus.num1} - {1'b0, bus.num2};

  // Shift-add: r_hi is the running upper half, r_lo the multiplier shifting out as product bits shift in.
  assign w_addend = r_lo[0] ? r_opb : '0;
  assign w_sum    = r_hi + {1'b0, w_addend};
  assign w_prod   = {w_sum, r_lo[WIDTH-1:1]};

  seq_alu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .i_rem (r_hi),
    .i_bit (r_lo[WIDTH-1]),
    .i_div (r_opb),
    .o_rem (w_rem_nxt),
    .o_q   (w_q)
  );

  assign w_divres = {r_lo[WIDTH-2:0], w_q, w_rem_nxt[WIDTH-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_res_nxt   = r_result;
    w_zero_nxt  = r_zero;
    w_dbz_nxt   = r_dbz;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          case (bus.sel)
            OP_ADD: begin
              w_state_nxt = DONE;
              w_res_nxt   = {{(WIDTH-1){1'b0}}, w_add};
              w_zero_nxt  = (w_add == '0);
              w_dbz_nxt   = 1'b0;
            end
            OP_SUB: begin
              w_state_nxt = DONE;
              w_res_nxt   = {{(WIDTH-1){1'b0}}, w_sub};
              w_zero_nxt  = (w_sub == '0);
              w_dbz_nxt   = 1'b0;
            end
            OP_MUL: w_state_nxt = MUL;
            default: begin
              if (bus.num2 == '0) begin
                w_state_nxt = DONE;
                w_res_nxt   = {{WIDTH{1'b0}}, bus.num1};
                w_zero_nxt  = (bus.num1 == '0);
                w_dbz_nxt   = 1'b1;
              end else begin
                w_state_nxt = DIV;
              end
            end
          endcase
        end
      end
      MUL: begin
        if (w_last) begin
          w_state_nxt = DONE;
          w_res_nxt   = w_prod;
          w_zero_nxt  = (w_prod == '0);
          w_dbz_nxt   = 1'b0;
        end
      end
      DIV: begin
        if (w_last) begin
          w_state_nxt = DONE;
          w_res_nxt   = w_divres;
          w_zero_nxt  = (w_rem_nxt == '0);
          w_dbz_nxt   = 1'b0;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_result <= w_res_nxt;
      r_zero   <= w_zero_nxt;
      r_dbz    <= w_dbz_nxt;
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_hi  <= '0;
            r_lo  <= bus.num1;
            r_opb <= bus.num2;
            r_cnt <= '0;
          end
        end
        MUL: begin
          r_hi  <= {1'b0, w_sum[WIDTH:1]};
          r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
        end
        DIV: begin
          r_hi  <= w_rem_nxt;
          r_lo  <= {r_lo[WIDTH-2:0], w_q};
          r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready         = (r_state == IDLE);
  assign bus.out_valid        = (r_state == DONE);
  assign bus.result           = r_result;
  assign bus.zero_flag        = r_zero;
  assign bus.div_by_zero_flag = r_dbz;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=8: directed table, backpressure and mid-operation reset sequences,
// then random operations against an arithmetic reference model.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        z;
    logic        d;
    int          lat;
  } vec_t;

  vec_t vt[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_res(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int x = int'(a);
    int y = int'(b);
    int r;
    case (op)
      2'd0:    r = x + y;
      2'd1:    r = ((x - y) & 255) + ((x < y) ? 256 : 0);
      2'd2:    r = x * y;
      default: r = (y == 0) ? x : (x / y) * 256 + (x % y);
    endcase
    return 16'(r);
  endfunction

  function automatic logic ref_zero(input logic [1:0] op, input logic [15:0] res);
    if (op == 2'd3) return (res[7:0] == 8'h00);
    return (res == 16'h0000);
  endfunction

  task automatic run_op(input string name, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_res, input logic exp_z, input logic exp_d,
                        input int exp_lat, input int hold);
    int lat;
    lat = 0;
    @(negedge clk);
    check({name, "/in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.sel      = op;
    bus.num1     = a;
    bus.num2     = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.num1     = 8'($urandom);
    bus.num2     = 8'($urandom);
    bus.sel      = 2'($urandom);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) check({name, "/in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
    check({name, "/latency"}, 32'(lat), 32'(exp_lat));
    check({name, "/result"}, 32'(bus.result), 32'(exp_res));
    check({name, "/zero_flag"}, 32'(bus.zero_flag), 32'(exp_z));
    check({name, "/div_by_zero"}, 32'(bus.div_by_zero_flag), 32'(exp_d));
    if (hold > 0) begin
      bus.in_valid = 1'b1;
      repeat (hold) @(negedge clk);
      bus.in_valid = 1'b0;
      check({name, "/result_held"}, 32'(bus.result), 32'(exp_res));
      check({name, "/valid_held"}, 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] er;
    int          got;

    n_vec = 0;
    n_err = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.num1      = '0;
    bus.num2      = '0;
    bus.sel       = '0;

    vt[0]  = '{OP_ADD, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b0, 1};
    vt[1]  = '{OP_SUB, 8'd3,   8'd5,   16'h01FE, 1'b0, 1'b0, 1};
    vt[2]  = '{OP_SUB, 8'd9,   8'd9,   16'h0000, 1'b1, 1'b0, 1};
    vt[3]  = '{OP_MUL, 8'd15,  8'd17,  16'h00FF, 1'b0, 1'b0, 9};
    vt[4]  = '{OP_MUL, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 9};
    vt[5]  = '{OP_REM, 8'd200, 8'd7,   16'h1C04, 1'b0, 1'b0, 9};
    vt[6]  = '{OP_REM, 8'd21,  8'd7,   16'h0300, 1'b1, 1'b0, 9};
    vt[7]  = '{OP_REM, 8'd5,   8'd0,   16'h0005, 1'b0, 1'b1, 1};
    vt[8]  = '{OP_ADD, 8'd0,   8'd0,   16'h0000, 1'b1, 1'b0, 1};
    vt[9]  = '{OP_ADD, 8'd255, 8'd255, 16'h01FE, 1'b0, 1'b0, 1};
    vt[10] = '{OP_REM, 8'd0,   8'd0,   16'h0000, 1'b1, 1'b1, 1};
    vt[11] = '{OP_MUL, 8'd0,   8'd200, 16'h0000, 1'b1, 1'b0, 9};
    vt[12] = '{OP_REM, 8'd3,   8'd200, 16'h0003, 1'b0, 1'b0, 9};
    vt[13] = '{OP_REM, 8'd255, 8'd1,   16'hFF00, 1'b1, 1'b0, 9};

    #12;
    check("reset/in_ready", 32'(bus.in_ready), 32'd1);
    check("reset/out_valid", 32'(bus.out_valid), 32'd0);
    check("reset/result", 32'(bus.result), 32'd0);
    check("reset/zero_flag", 32'(bus.zero_flag), 32'd0);
    check("reset/div_by_zero", 32'(bus.div_by_zero_flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].z, vt[i].d, vt[i].lat, 0);
    end

    // Backpressure: completed MUL waits 5 cycles with a competing request pending.
    @(negedge clk);
    bus.sel = OP_MUL; bus.num1 = 8'd15; bus.num2 = 8'd17; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    got = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1;
        break;
      end
    end
    check("bp/valid", 32'(got), 32'd1);
    bus.sel = OP_ADD; bus.num1 = 8'd1; bus.num2 = 8'd1; bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp/result_stable", 32'(bus.result), 32'h00FF);
      check("bp/in_ready_low", 32'(bus.in_ready), 32'd0);
      check("bp/out_valid_high", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp/released_valid", 32'(bus.out_valid), 32'd0);
    check("bp/released_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp/next_valid", 32'(bus.out_valid), 32'd1);
    check("bp/next_result", 32'(bus.result), 32'h0002);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // Reset asserted four edges into a MUL.
    @(negedge clk);
    bus.sel = OP_MUL; bus.num1 = 8'd255; bus.num2 = 8'd255; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst/in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst/out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst/result", 32'(bus.result), 32'd0);
    check("midrst/zero_flag", 32'(bus.zero_flag), 32'd0);
    check("midrst/div_by_zero", 32'(bus.div_by_zero_flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_add", OP_ADD, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b0, 1, 0);

    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom);
      a  = 8'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      er = ref_res(op, a, b);
      run_op($sformatf("rnd%0d", i), op, a, b, er, ref_zero(op, er),
             (op == OP_REM && b == 8'h00) ? 1'b1 : 1'b0,
             (op == OP_MUL || (op == OP_REM && b != 8'h00)) ? W + 1 : 1,
             int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
